// File: rtl/ifetch_if.sv
// Fetch-unit bus: ROM read port, decode-side valid/ready queue output and
// execute-side redirect input.
interface ifetch_if;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_err;

  modport master (
    output rom_address, ins_valid, ins, ins_pc, fetch_err,
    input  rom_data, ins_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  rom_address, ins_valid, ins, ins_pc, fetch_err,
    output rom_data, ins_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC-driven ROM reads buffered with their PC in a small
// FIFO toward decode; handles redirects, end-of-ROM stop and misaligned-target error.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] ROM_LIMIT = 32'h0000_0080,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic     clk,
  input  logic     reset,
  ifetch_if.master io_bus
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {StFetch, StDone, StError} state_e;

  state_e        r_state, w_state_next;
  logic [31:0]   r_pc, w_pc_next;
  logic [31:0]   r_mem_ins [QDEPTH];
  logic [31:0]   r_mem_pc  [QDEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  logic w_ins_valid, w_pop, w_push, w_flush, w_redir_ok, w_redir_bad;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Any redirect outside ERROR empties the queue, aligned or not.
  assign w_flush     = io_bus.redirect_valid && (r_state != StError);
  assign w_redir_ok  = w_flush && (io_bus.redirect_target[1:0] == 2'b00);
  assign w_redir_bad = w_flush && (io_bus.redirect_target[1:0] != 2'b00);
  assign w_ins_valid = (r_count != '0) && (r_state != StError);
  assign w_pop       = w_ins_valid && io_bus.ins_ready;
  assign w_push      = (r_state == StFetch) && !io_bus.redirect_valid &&
                       (r_pc < ROM_LIMIT) && ((r_count < DEPTH_C) || w_pop);

  always_comb begin
    w_pc_next = r_pc;
    if (w_redir_ok) begin
      w_pc_next = io_bus.redirect_target;
    end else if (w_push) begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFetch, StDone: begin
        if (w_redir_bad) begin
          w_state_next = StError;
        end else if (w_redir_ok) begin
          w_state_next = (io_bus.redirect_target >= ROM_LIMIT) ? StDone : StFetch;
        end else if (w_pc_next >= ROM_LIMIT) begin
          w_state_next = StDone;
        end
      end
      default: w_state_next = StError;
    endcase
  end

  // Outputs
  always_comb begin
    io_bus.rom_address = r_pc;
    io_bus.ins_valid   = w_ins_valid;
    io_bus.ins         = r_mem_ins[r_head];
    io_bus.ins_pc      = r_mem_pc[r_head];
    io_bus.fetch_err   = (r_state == StError);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        r_mem_ins[i] <= '0;
        r_mem_pc[i]  <= '0;
      end
    end else begin
      r_pc <= w_pc_next;
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem_ins[r_tail] <= io_bus.rom_data;
          r_mem_pc[r_tail]  <= r_pc;
          r_tail            <= ptr_inc(r_tail);
        end
        if (w_pop) begin
          r_head <= ptr_inc(r_head);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, backpressure, redirect flush,
// end-of-ROM drain, misaligned-redirect error and reset priority.
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] rom [32];

  ifetch_if bus ();

  ifetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ROM_LIMIT(32'h0000_0080),
    .QDEPTH   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = (bus.rom_address < 32'h80) ? rom[bus.rom_address[6:2]] : 32'h0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return rom[a[6:2]];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    bus.ins_ready = rdy;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ins_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    repeat (3) step();
    total++; if (bus.ins_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.ins_valid); end
    total++; if (bus.ins !== 32'h0) begin bad++; $display("FAIL reset_ins got %h want 0", bus.ins); end
    total++; if (bus.ins_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h want 0", bus.ins_pc); end
    total++; if (bus.fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", bus.fetch_err); end
    total++; if (bus.rom_address !== 32'h0) begin bad++; $display("FAIL reset_addr got %h want 0", bus.rom_address); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    step();
    total++; if (bus.ins_valid !== 1'b1) begin bad++; $display("FAIL stream_first_valid got %b want 1", bus.ins_valid); end
    total++; if (bus.ins !== 32'h8C020004) begin bad++; $display("FAIL stream_first_ins got %h want 8c020004", bus.ins); end
    for (int k = 1; k < 6; k++) begin
      step();
      total++;
      if (bus.ins_pc !== 32'(4 * k) || bus.ins !== rom_word(32'(4 * k)) || bus.ins_valid !== 1'b1) begin
        bad++;
        $display("FAIL stream_seq got pc=%h ins=%h v=%b want pc=%h ins=%h v=1",
                 bus.ins_pc, bus.ins, bus.ins_valid, 32'(4 * k), rom_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    repeat (5) step();
    total++; if (bus.rom_address !== 32'h8) begin bad++; $display("FAIL bp_pc_stall got %h want 8", bus.rom_address); end
    total++; if (bus.ins !== 32'h8C020004 || bus.ins_pc !== 32'h0) begin bad++; $display("FAIL bp_hold got ins=%h pc=%h want 8c020004/0", bus.ins, bus.ins_pc); end
    bus.ins_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      total++;
      if (bus.ins_pc !== 32'(4 * k) || bus.ins_valid !== 1'b1) begin
        bad++; $display("FAIL bp_release got pc=%h v=%b want pc=%h v=1", bus.ins_pc, bus.ins_valid, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    logic found = 1'b0;
    do_reset(1'b1);
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (bus.ins_valid === 1'b1 && bus.ins_pc === 32'h18) found = 1'b1;
    end
    total++; if (!found || bus.ins !== 32'h10C0FFFD) begin bad++; $display("FAIL redir_reach got pc=%h ins=%h want 18/10c0fffd", bus.ins_pc, bus.ins); end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h10;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.ins_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got v=%b want 0", bus.ins_valid); end
    step();
    total++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h10 || bus.ins !== rom_word(32'h10)) begin
      bad++; $display("FAIL redir_target got v=%b pc=%h want 1/10", bus.ins_valid, bus.ins_pc);
    end
    step();
    total++; if (bus.ins_pc !== 32'h14) begin bad++; $display("FAIL redir_next got %h want 14", bus.ins_pc); end
  endtask

  task automatic test_done();
    logic found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (bus.ins_valid === 1'b1 && bus.ins_pc === 32'h7C) found = 1'b1;
    end
    total++; if (!found || bus.ins !== rom_word(32'h7C)) begin bad++; $display("FAIL done_last got pc=%h want 7c", bus.ins_pc); end
    total++; if (bus.rom_address !== 32'h80) begin bad++; $display("FAIL done_addr got %h want 80", bus.rom_address); end
    step();
    total++; if (bus.ins_valid !== 1'b0) begin bad++; $display("FAIL done_drain got v=%b want 0", bus.ins_valid); end
    step();
    total++; if (bus.ins_valid !== 1'b0 || bus.rom_address !== 32'h80) begin
      bad++; $display("FAIL done_idle got v=%b addr=%h want 0/80", bus.ins_valid, bus.rom_address);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    step();
    total++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h0) begin
      bad++; $display("FAIL done_resume got v=%b pc=%h want 1/0", bus.ins_valid, bus.ins_pc);
    end
  endtask

  task automatic test_error();
    logic [31:0] pc_before;
    step();
    pc_before = bus.rom_address;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h6;
    step();
    total++; if (bus.fetch_err !== 1'b1 || bus.ins_valid !== 1'b0) begin
      bad++; $display("FAIL err_set got err=%b v=%b want 1/0", bus.fetch_err, bus.ins_valid);
    end
    total++; if (bus.rom_address !== pc_before) begin bad++; $display("FAIL err_pc got %h want %h", bus.rom_address, pc_before); end
    bus.redirect_target = 32'h0;
    repeat (2) step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.fetch_err !== 1'b1 || bus.ins_valid !== 1'b0 || bus.rom_address !== pc_before) begin
      bad++; $display("FAIL err_sticky got err=%b v=%b addr=%h want 1/0/%h", bus.fetch_err, bus.ins_valid, bus.rom_address, pc_before);
    end
    reset = 1'b1;
    step();
    total++; if (bus.fetch_err !== 1'b0) begin bad++; $display("FAIL err_clear got %b want 0", bus.fetch_err); end
    reset = 1'b0;
    step();
    total++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h0) begin
      bad++; $display("FAIL err_restart got v=%b pc=%h want 1/0", bus.ins_valid, bus.ins_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    repeat (3) step();
    reset = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h42;
    step();
    total++; if (bus.ins_valid !== 1'b0 || bus.fetch_err !== 1'b0 || bus.rom_address !== 32'h0) begin
      bad++; $display("FAIL rstmid_state got v=%b err=%b addr=%h want 0/0/0", bus.ins_valid, bus.fetch_err, bus.rom_address);
    end
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.ins_ready = 1'b1;
    step();
    total++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h0 || bus.ins !== 32'h8C020004) begin
      bad++; $display("FAIL rstmid_first got v=%b pc=%h ins=%h want 1/0/8c020004", bus.ins_valid, bus.ins_pc, bus.ins);
    end
    step();
    total++; if (bus.ins_pc !== 32'h4) begin bad++; $display("FAIL rstmid_second got %h want 4", bus.ins_pc); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 | 32'(i * 4);
    rom[0] = 32'h8C020004;  // lw
    rom[1] = 32'h8C030008;  // lw
    rom[2] = 32'h00622020;  // add
    rom[3] = 32'h0064282A;  // slt
    rom[6] = 32'h10C0FFFD;  // beq
    rom[7] = 32'hAC050010;  // sw
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_done();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
